// File: rtl/video_timing_gen.sv
// video_timing_gen: raster position counter with blanking, sync and line/frame pulse decode.
// Latency: every output is a register describing the hpos/vpos presented in the same cycle.
// Backpressure: ce=0 freezes position, VDE, CD and frame_cnt; line/frame pulses still self-clear.
module video_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int FRAME_W  = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic               pixclk,
    input  logic               rst,
    input  logic               ce,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               VDE,
    output logic [1:0]         CD,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    // Last legal column/line; the counters wrap from here back to zero.
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Decode thresholds carry one extra bit: the sync end can equal the total,
    // which does not fit in HW/VW bits when the total is a power of two.
    localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    // Pin level of each sync while asserted.
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;
    logic          vde_nxt;
    logic          hs_act_nxt;
    logic          vs_act_nxt;
    logic [1:0]    cd_nxt;
    logic          line_nxt;
    logic          frame_nxt;

    // Next raster position; >= instead of == keeps the counters in range even
    // if a register were ever upset past the last legal value.
    always_comb begin
        h_wrap = (hpos >= H_LAST);
        v_wrap = (vpos >= V_LAST);
        h_nxt  = h_wrap ? '0 : hpos + HW'(1);
        v_nxt  = vpos;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vpos + VW'(1);
        end
    end

    // Decode blanking, sync and pulses from the next position so the registered
    // outputs line up with the registered position (no pipeline skew).
    always_comb begin
        h_ext      = {1'b0, h_nxt};
        v_ext      = {1'b0, v_nxt};
        vde_nxt    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hs_act_nxt = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
        vs_act_nxt = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
        cd_nxt     = {vs_act_nxt ? VS_ON : ~VS_ON, hs_act_nxt ? HS_ON : ~HS_ON};
        line_nxt   = (h_nxt == '0);
        frame_nxt  = (h_nxt == '0) && (v_nxt == '0);
    end

    // Output registers: reset parks the raster on its last pixel so the first
    // enabled edge lands on (0,0) and opens frame 1.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            VDE         <= 1'b0;
            CD          <= {~VS_ON, ~HS_ON};
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                hpos        <= h_nxt;
                vpos        <= v_nxt;
                VDE         <= vde_nxt;
                CD          <= cd_nxt;
                line_start  <= line_nxt;
                frame_start <= frame_nxt;
                if (frame_nxt) begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three geometries (default, medium, tiny) driven by shared rst/ce,
// each compared every cycle against an arithmetic raster model, plus a vector table
// for the tiny geometry and hand sequences for line period, sync span and mid-frame reset.
module tb_video_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, fw;
    } geom_t;

    typedef struct {
        int h, v, vde, cd, ls, fs, fc;
    } obs_t;

    typedef struct {
        bit r;
        bit c;
        int h, v, vde, cd, ls, fs, fc;
    } vec_t;

    logic pixclk;
    logic rst;
    logic ce;

    // default geometry: 1056 x 628
    logic [10:0] def_hpos;
    logic [9:0]  def_vpos;
    logic        def_vde;
    logic [1:0]  def_cd;
    logic        def_ls, def_fs;
    logic [7:0]  def_fc;

    // medium geometry: 58 x 40, hsync active-low, vsync active-high
    logic [5:0]  med_hpos;
    logic [5:0]  med_vpos;
    logic        med_vde;
    logic [1:0]  med_cd;
    logic        med_ls, med_fs;
    logic [2:0]  med_fc;

    // tiny geometry: 8 x 6, both syncs active-high
    logic [2:0]  tin_hpos;
    logic [2:0]  tin_vpos;
    logic        tin_vde;
    logic [1:0]  tin_cd;
    logic        tin_ls, tin_fs;
    logic [1:0]  tin_fc;

    video_timing_gen u_def (
        .pixclk(pixclk), .rst(rst), .ce(ce),
        .hpos(def_hpos), .vpos(def_vpos), .VDE(def_vde), .CD(def_cd),
        .line_start(def_ls), .frame_start(def_fs), .frame_cnt(def_fc)
    );

    video_timing_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(3), .V_BP(5),
        .HS_POL(0), .VS_POL(1), .FRAME_W(3)
    ) u_med (
        .pixclk(pixclk), .rst(rst), .ce(ce),
        .hpos(med_hpos), .vpos(med_vpos), .VDE(med_vde), .CD(med_cd),
        .line_start(med_ls), .frame_start(med_fs), .frame_cnt(med_fc)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .FRAME_W(2)
    ) u_tin (
        .pixclk(pixclk), .rst(rst), .ce(ce),
        .hpos(tin_hpos), .vpos(tin_vpos), .VDE(tin_vde), .CD(tin_cd),
        .line_start(tin_ls), .frame_start(tin_fs), .frame_cnt(tin_fc)
    );

    geom_t g_def = '{800, 40, 128, 88, 600, 1, 4, 23, 0, 0, 8};
    geom_t g_med = '{40, 4, 8, 6, 30, 2, 3, 5, 0, 1, 3};
    geom_t g_tin = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 2};

    int   n_chk = 0;
    int   n_err = 0;
    int   tick  = 0;     // ce=1 edges since the last reset
    bit   last_ce = 0;   // previous edge advanced the raster
    obs_t a_def, a_med, a_tin;

    initial begin
        pixclk = 1'b0;
        forever #5 pixclk = ~pixclk;
    end

    // Raster as a pure function of enabled-edge count: position index p runs
    // 0..total-1 and the reset state sits at index total-1.
    function automatic obs_t model(input geom_t g, input int tk, input bit lc);
        obs_t e;
        int ht, vt, tot, p, hs_on, vs_on;
        ht  = g.ha + g.hf + g.hs + g.hb;
        vt  = g.va + g.vf + g.vs + g.vb;
        tot = ht * vt;
        p   = (tk == 0) ? tot - 1 : (tk - 1) % tot;
        e.h = p % ht;
        e.v = p / ht;
        e.vde = (e.h < g.ha && e.v < g.va) ? 1 : 0;
        hs_on = (e.h >= g.ha + g.hf && e.h < g.ha + g.hf + g.hs) ? 1 : 0;
        vs_on = (e.v >= g.va + g.vf && e.v < g.va + g.vf + g.vs) ? 1 : 0;
        e.cd = 2 * (vs_on != 0 ? g.vpol : 1 - g.vpol) + (hs_on != 0 ? g.hpol : 1 - g.hpol);
        e.ls = (lc && e.h == 0) ? 1 : 0;
        e.fs = (lc && p == 0) ? 1 : 0;
        e.fc = (tk == 0) ? 0 : (((tk - 1) / tot) + 1) % (1 << g.fw);
        return e;
    endfunction

    function automatic bit same(input obs_t a, input obs_t b);
        return a.h == b.h && a.v == b.v && a.vde == b.vde && a.cd == b.cd &&
               a.ls == b.ls && a.fs == b.fs && a.fc == b.fc;
    endfunction

    task automatic check_obs(input string nm, input obs_t a, input obs_t e);
        n_chk++;
        if (!same(a, e)) begin
            n_err++;
            $display("FAIL %s t=%0d: got h=%0d v=%0d vde=%0d cd=%0d ls=%0d fs=%0d fc=%0d, want h=%0d v=%0d vde=%0d cd=%0d ls=%0d fs=%0d fc=%0d",
                     nm, tick, a.h, a.v, a.vde, a.cd, a.ls, a.fs, a.fc,
                     e.h, e.v, e.vde, e.cd, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample at the falling edge.
    task automatic step(input bit r, input bit c);
        rst = r;
        ce  = c;
        @(posedge pixclk);
        if (r) begin
            tick = 0;
            last_ce = 0;
        end else if (c) begin
            tick++;
            last_ce = 1;
        end else begin
            last_ce = 0;
        end
        @(negedge pixclk);
        a_def = '{int'(def_hpos), int'(def_vpos), int'(def_vde), int'(def_cd),
                  int'(def_ls), int'(def_fs), int'(def_fc)};
        a_med = '{int'(med_hpos), int'(med_vpos), int'(med_vde), int'(med_cd),
                  int'(med_ls), int'(med_fs), int'(med_fc)};
        a_tin = '{int'(tin_hpos), int'(tin_vpos), int'(tin_vde), int'(tin_cd),
                  int'(tin_ls), int'(tin_fs), int'(tin_fc)};
        check_obs("model_def", a_def, model(g_def, tick, last_ce));
        check_obs("model_med", a_med, model(g_med, tick, last_ce));
        check_obs("model_tiny", a_tin, model(g_tin, tick, last_ce));
    endtask

    vec_t vecs[16];

    initial begin
        obs_t e;
        int   first_ls, second_ls, hs_cnt, hs_min, hs_max, med_vde_cnt, nf;
        int   fc_seen[4];
        int   fc_want[4];

        // tiny geometry: h 0..3 active, 4 fp, 5..6 sync, 7 bp; v 0..2 active, 3 fp, 4 sync, 5 bp
        //            r  c  h  v vde cd ls fs fc
        vecs[0]  = '{1, 0, 7, 5, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 7, 5, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 7, 5, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 1, 0, 1, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        vecs[5]  = '{0, 1, 1, 0, 1, 0, 0, 0, 1};
        vecs[6]  = '{0, 1, 2, 0, 1, 0, 0, 0, 1};
        vecs[7]  = '{0, 1, 3, 0, 1, 0, 0, 0, 1};
        vecs[8]  = '{0, 1, 4, 0, 0, 0, 0, 0, 1};
        vecs[9]  = '{0, 1, 5, 0, 0, 1, 0, 0, 1};
        vecs[10] = '{0, 1, 6, 0, 0, 1, 0, 0, 1};
        vecs[11] = '{0, 1, 7, 0, 0, 0, 0, 0, 1};
        vecs[12] = '{0, 1, 0, 1, 1, 0, 1, 0, 1};
        vecs[13] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
        vecs[14] = '{1, 1, 7, 5, 0, 0, 0, 0, 0};
        vecs[15] = '{0, 1, 0, 0, 1, 0, 1, 1, 1};
        fc_want  = '{1, 2, 3, 0};

        rst = 1'b1;
        ce  = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].c);
            e = '{vecs[i].h, vecs[i].v, vecs[i].vde, vecs[i].cd,
                  vecs[i].ls, vecs[i].fs, vecs[i].fc};
            check_obs($sformatf("vec%0d", i), a_tin, e);
        end

        // Continuous ce from reset: one full medium frame, two-plus default lines.
        step(1, 0);
        check_int("reset_cd_tiny", a_tin.cd, 0);
        check_int("reset_cd_def", a_def.cd, 3);
        first_ls = -1;
        second_ls = -1;
        hs_cnt = 0;
        hs_min = 99999;
        hs_max = -1;
        med_vde_cnt = 0;
        nf = 0;
        for (int k = 1; k <= 2320; k++) begin
            step(0, 1);
            if (a_def.ls == 1) begin
                if (first_ls < 0) first_ls = k;
                else if (second_ls < 0) second_ls = k;
            end
            if (a_def.v == 0 && (a_def.cd % 2) == 0) begin
                hs_cnt++;
                if (a_def.h < hs_min) hs_min = a_def.h;
                if (a_def.h > hs_max) hs_max = a_def.h;
            end
            if (a_med.vde == 1) med_vde_cnt++;
            if (a_tin.fs == 1 && nf < 4) begin
                fc_seen[nf] = a_tin.fc;
                nf++;
            end
        end
        check_int("line_period", second_ls - first_ls, 1056);
        check_int("hsync_width", hs_cnt, 128);
        check_int("hsync_first", hs_min, 840);
        check_int("hsync_last", hs_max, 967);
        check_int("med_vde_per_frame", med_vde_cnt, 40 * 30);
        check_int("tiny_frames_seen", nf, 4);
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("tiny_fc_seq%0d", i), fc_seen[i], fc_want[i]);
        end

        // Mid-frame reset at (500,2) on the default geometry.
        step(1, 0);
        for (int k = 0; k < 2613; k++) step(0, 1);
        check_int("pre_rst_h", a_def.h, 500);
        check_int("pre_rst_v", a_def.v, 2);
        step(1, 1);
        check_int("rst_h", a_def.h, 1055);
        check_int("rst_v", a_def.v, 627);
        check_int("rst_vde", a_def.vde, 0);
        check_int("rst_fc", a_def.fc, 0);
        check_int("rst_fs", a_def.fs, 0);
        step(0, 1);
        check_int("post_rst_h", a_def.h, 0);
        check_int("post_rst_v", a_def.v, 0);
        check_int("post_rst_fs", a_def.fs, 1);
        check_int("post_rst_fc", a_def.fc, 1);

        // Random ce and occasional resets, checked by the model each cycle.
        for (int k = 0; k < 6000; k++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch clocks
- H_SYNC, 128, hsync width clocks
- H_BP, 88, horizontal back porch clocks
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch lines
- V_SYNC, 4, vsync width lines
- V_BP, 23, vertical back porch lines
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- FRAME_W, 8, frame counter width
REQ-002 Derived constants SHALL be H_TOTAL = sum of the four H parameters and V_TOTAL = sum of the four V parameters; HW = clog2(H_TOTAL) and VW = clog2(V_TOTAL).
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- pixclk  in  1  pixel clock, the only clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel advance enable
- hpos  out  HW  current column, 0..H_TOTAL-1
- vpos  out  VW  current line, 0..V_TOTAL-1
- VDE  out  1  video data enable
- CD  out  2  {vsync, hsync} at pin polarity
- line_start  out  1  one-clock pulse at hpos=0
- frame_start  out  1  one-clock pulse at (0,0)
- frame_cnt  out  FRAME_W  completed-frame counter

Function
REQ-004 All outputs SHALL be registers; VDE, CD and the pulses SHALL describe the hpos/vpos value presented in the same cycle (zero skew).
REQ-005 On an edge with ce=1, hpos SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment; at (H_TOTAL-1, V_TOTAL-1) both SHALL wrap to 0.
REQ-006 On an edge with ce=0, hpos, vpos, VDE, CD and frame_cnt SHALL hold.
REQ-007 VDE SHALL be 1 iff hpos < H_ACTIVE and vpos < V_ACTIVE.
REQ-008 hsync SHALL be active iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC; CD[0] SHALL equal HS_POL when active and ~HS_POL otherwise.
REQ-009 vsync SHALL be active iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC, for the whole line including hblank; CD[1] SHALL use VS_POL in the same way.
REQ-010 line_start SHALL be 1 only in the cycle after a ce=1 edge that moves hpos to 0, and SHALL clear on the next edge regardless of ce.
REQ-011 frame_start SHALL follow the same rule at the wrap to (0,0).
REQ-012 frame_cnt SHALL increment by 1, modulo 2^FRAME_W, on the edge that raises frame_start.
REQ-013 Counter arithmetic SHALL never present hpos >= H_TOTAL or vpos >= V_TOTAL.

Reset
REQ-014 rst=1 at an edge SHALL take priority over ce and SHALL load hpos=H_TOTAL-1, vpos=V_TOTAL-1, VDE=0, CD={~VS_POL,~HS_POL}, line_start=0, frame_start=0, frame_cnt=0.
REQ-015 The first ce=1 edge after reset release SHALL present (0,0) with VDE=1, line_start=1 and frame_start=1, and frame_cnt SHALL become 1.
REQ-016 rst asserted mid-frame SHALL abort the frame immediately with the REQ-014 values; no partial pulse SHALL survive.

Verification
REQ-017 Defaults, ce=1: after reset, hsync low exactly for hpos 840..967; line period 1056 clocks; frame period 663168 clocks; vsync low for lines 601..604.
REQ-018 Defaults: VDE high count per frame = 480000; VDE=0 at (800,0) and at (0,600); VDE=1 at (799,599).
REQ-019 ce toggling 1,0,1,0: every output advances only on ce=1 edges; line_start width = 1 clock even with ce=0 the cycle after.
REQ-020 HS_POL=1, VS_POL=1: idle CD=2'b00; during hsync CD[0]=1; reset value CD=2'b00.
REQ-021 Tiny timing (H 4/1/2/1, V 3/1/1/1, FRAME_W=2): hpos cycles 0..7, vpos 0..5; frame_cnt sequence 1,2,3,0 over four frames.
REQ-022 rst pulsed at (500,300): next cycle state (1055,627), VDE=0, frame_cnt=0; the following ce=1 edge gives (0,0) with frame_start=1.
